// File: rtl/spike_rate_encoder.sv
// Rate-coded spike encoder: latches one sample of NUM_INPUTS intensities and plays it
// out as a NUM_TIMESTEPS spike train. Define SPIKE_LFSR_EN for stochastic LFSR coding.
module spike_rate_encoder #(
   parameter int          NUM_INPUTS    = 8,
   parameter int          PIXEL_WIDTH   = 8,
   parameter int          NUM_TIMESTEPS = 16,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pixel_in,
   input  logic                              load_valid,
   output logic                              load_ready,
   input  logic                              start,
   input  logic                              abort,
   output logic [NUM_INPUTS-1:0]             spike_out,
   output logic                              spike_valid,
   output logic [15:0]                       timestep,
   output logic                              done
);

   localparam logic [15:0] LAST_STEP = 16'(NUM_TIMESTEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOADED,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic                    load_ready_q, load_ready_d;
   logic                    spike_valid_q, spike_valid_d;
   logic                    done_q, done_d;
   logic [15:0]             timestep_q, timestep_d;
   logic [15:0]             step_q, step_d;
   logic                    issued_q, issued_d;
   logic [NUM_INPUTS-1:0]   spike_q, spike_d;
   logic [NUM_INPUTS-1:0]   spike_bit;

   logic load_fire;
   logic start_fire;
   logic compute;

   // Abort outranks load, and load outranks start when both arrive in LOADED.
   assign load_fire  = load_valid && load_ready_q && !abort;
   assign start_fire = start && (state_q == ST_LOADED) && !abort && !load_fire;
   assign compute    = (state_q == ST_RUN) && !issued_q && !abort;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
         logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;

         always_comb begin
            pixel_d = pixel_q;
            if (abort) begin
               pixel_d = '0;
            end else if (load_fire) begin
               pixel_d = pixel_in[gi*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               pixel_q <= '0;
            end else begin
               pixel_q <= pixel_d;
            end
         end

`ifdef SPIKE_LFSR_EN
         localparam logic [15:0] SEED = LFSR_SEED ^ 16'(gi + 1);

         logic [15:0] lfsr_q, lfsr_d, lfsr_adv;

         // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
         assign lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

         always_comb begin
            lfsr_d = lfsr_q;
            if (start_fire) begin
               lfsr_d = SEED;
            end else if (compute) begin
               lfsr_d = lfsr_adv;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               lfsr_q <= SEED;
            end else begin
               lfsr_q <= lfsr_d;
            end
         end

         assign spike_bit[gi] = (pixel_q > lfsr_q[PIXEL_WIDTH-1:0]);
`else
         logic [PIXEL_WIDTH-1:0] acc_q, acc_d;
         logic [PIXEL_WIDTH:0]   sum;

         // The carry out of the phase accumulator is the spike.
         assign sum = {1'b0, acc_q} + {1'b0, pixel_q};

         always_comb begin
            acc_d = acc_q;
            if (start_fire) begin
               acc_d = '0;
            end else if (compute) begin
               acc_d = sum[PIXEL_WIDTH-1:0];
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               acc_q <= '0;
            end else begin
               acc_q <= acc_d;
            end
         end

         assign spike_bit[gi] = sum[PIXEL_WIDTH];
`endif
      end

`ifndef SPIKE_LFSR_EN
      // The seed only matters for the stochastic build.
      if (LFSR_SEED == 16'h0000) begin : g_seed_unused
      end
`endif
   endgenerate

   // RUN spends NUM_TIMESTEPS cycles computing plus one cycle draining the last
   // registered spike, so done lands exactly one cycle after the final timestep.
   always_comb begin
      state_d       = state_q;
      spike_valid_d = 1'b0;
      done_d        = 1'b0;
      timestep_d    = timestep_q;
      step_d        = step_q;
      issued_d      = issued_q;
      spike_d       = compute ? spike_bit : '0;

      if (abort) begin
         state_d    = ST_IDLE;
         timestep_d = '0;
         step_d     = '0;
         issued_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_fire) begin
                  state_d = ST_LOADED;
               end
            end
            ST_LOADED: begin
               if (start_fire) begin
                  state_d    = ST_RUN;
                  step_d     = '0;
                  issued_d   = 1'b0;
                  timestep_d = '0;
               end
            end
            ST_RUN: begin
               if (!issued_q) begin
                  spike_valid_d = 1'b1;
                  timestep_d    = step_q;
                  if (step_q == LAST_STEP) begin
                     issued_d = 1'b1;
                  end else begin
                     step_d = step_q + 16'd1;
                  end
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      load_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOADED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         load_ready_q  <= 1'b0;
         spike_valid_q <= 1'b0;
         done_q        <= 1'b0;
         timestep_q    <= '0;
         step_q        <= '0;
         issued_q      <= 1'b0;
         spike_q       <= '0;
      end else begin
         state_q       <= state_d;
         load_ready_q  <= load_ready_d;
         spike_valid_q <= spike_valid_d;
         done_q        <= done_d;
         timestep_q    <= timestep_d;
         step_q        <= step_d;
         issued_q      <= issued_d;
         spike_q       <= spike_d;
      end
   end

   assign load_ready  = load_ready_q;
   assign spike_out   = spike_q;
   assign spike_valid = spike_valid_q;
   assign timestep    = timestep_q;
   assign done        = done_q;

endmodule

// File: doc/spike_rate_encoder.md
SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 8: number of pixel channels and spike outputs.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8, legal 1..16: intensity width per channel.
REQ-003 SHALL have parameter NUM_TIMESTEPS, default 16, legal 1..65535: spike-train length per sample.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1: base seed, used only under SPIKE_LFSR_EN.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 SHALL have port pixel_in  input  NUM_INPUTS*PIXEL_WIDTH  packed intensities; channel i at bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-008 SHALL have port load_valid  input  1  pixel_in valid this cycle.
REQ-009 SHALL have port load_ready  output  1  encoder accepts a load.
REQ-010 SHALL have port start  input  1  begin spike train for the stored sample.
REQ-011 SHALL have port abort  input  1  synchronous cancel.
REQ-012 SHALL have port spike_out  output  NUM_INPUTS  registered spikes; directly drives the IF network's spike_in.
REQ-013 SHALL have port spike_valid  output  1  spike_out is a live timestep.
REQ-014 SHALL have port timestep  output  16  index of the current timestep, 0-based.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final timestep.

Function
REQ-016 SHALL implement FSM IDLE, LOADED, RUN, DONE.
REQ-017 SHALL assert load_ready in IDLE and LOADED only; load = load_valid && load_ready, capturing pixel_in into per-channel registers.
REQ-018 SHALL move IDLE->LOADED on load; a load in LOADED overwrites the stored sample.
REQ-019 SHALL ignore start in IDLE, RUN and DONE; start in LOADED (load wins if same cycle: stored sample updated, state stays LOADED) moves to RUN next cycle.
REQ-020 SHALL, on entering RUN, clear each channel accumulator to 0 and timestep to 0.
REQ-021 SHALL, each RUN cycle, compute per channel sum = acc + pixel (PIXEL_WIDTH+1 bits), set acc <= sum[PIXEL_WIDTH-1:0], spike_out[i] <= sum[PIXEL_WIDTH].
REQ-022 SHALL yield exactly floor(pixel*NUM_TIMESTEPS / 2^PIXEL_WIDTH) spikes per channel per train.
REQ-023 SHALL assert spike_valid for exactly NUM_TIMESTEPS consecutive cycles, one cycle after each RUN cycle, with timestep matching the asserted spike_out.
REQ-024 SHALL move RUN->DONE after timestep NUM_TIMESTEPS-1; DONE lasts one cycle with done=1, spike_out=0, spike_valid=0, then IDLE.
REQ-025 SHALL hold spike_out=0 whenever spike_valid=0.
REQ-026 SHALL, on abort in any state, go to IDLE next cycle, clear spike_out, spike_valid, done and discard the stored sample; abort has priority over load and start.
REQ-027 SHALL wrap no counter; timestep saturates at NUM_TIMESTEPS-1 by construction.

Reset
REQ-028 SHALL, while rst=0, force state IDLE, spike_out=0, spike_valid=0, timestep=0, done=0, pixel registers=0, accumulators=0, and LFSRs=their seeds; load_ready=1 after release.
REQ-029 SHALL abandon any train in progress on reset with no done pulse.

Configuration
REQ-030 SHALL, with SPIKE_LFSR_EN defined, replace REQ-021/022 by stochastic coding: per-channel 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1), seed LFSR_SEED ^ (i+1), reloaded on entering RUN, advanced each RUN cycle; spike_out[i] <= (pixel > lfsr[PIXEL_WIDTH-1:0]).
REQ-031 SHALL, without SPIKE_LFSR_EN, use the deterministic accumulator and instantiate no LFSR logic; all other timing is identical in both builds.

Verification
REQ-032 SHALL cover: load all channels 64, start -> ch spikes at timesteps 3,7,11,15 (4 total), done one cycle after timestep 15.
REQ-033 SHALL cover: channels {0,128,255,1,...} -> counts 0, 8 (first at timestep 1), 15, 0 over 16 timesteps.
REQ-034 SHALL cover: start asserted in IDLE with no load -> no spike_valid, state stays IDLE; load+start same cycle -> LOADED, no run.
REQ-035 SHALL cover: abort at timestep 5 -> spike_valid low next cycle, no done, load_ready high; new load/start gives full 16-step train.
REQ-036 SHALL cover: rst low at timestep 7 -> all outputs 0 immediately, IDLE after release.
REQ-037 SHALL cover (SPIKE_LFSR_EN): pixel 0 -> 0 spikes; two runs of same sample -> identical spike trains.
